// File: rtl/frac_lut4_ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: state encoding and sizing helpers.
package frac_lut4_ccff_loader_pkg;

   // Loader FSM encoding
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   // Number of bitstream words needed to cover a chain of chain_len bits
   function automatic int unsigned ccff_nwords(input int unsigned chain_len,
                                               input int unsigned data_w);
      return (chain_len + data_w - 1) / data_w;
   endfunction

   // Width of a counter that must reach max_val without wrapping
   function automatic int unsigned ccff_cnt_w(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/frac_lut4_ccff_serializer.sv
// Word-to-bit serializer: one holding register feeding one right-shifting register.
module frac_lut4_ccff_serializer
   import frac_lut4_ccff_loader_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              clear,
   input  logic              load_en,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift,
   output logic              hold_valid,
   output logic              sreg_nonempty,
   output logic              sreg_bit0
);

   localparam int unsigned SCNT_W = ccff_cnt_w(DATA_W);
   localparam logic [SCNT_W-1:0] SCNT_FULL = SCNT_W'(DATA_W);
   localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [SCNT_W-1:0] sreg_cnt_q, sreg_cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic              sreg_empty;
   logic              last_bit;
   logic              transfer;

   // Next-state for the shift and holding registers
   always_comb begin
      sreg_empty   = (sreg_cnt_q == '0);
      last_bit     = shift && (sreg_cnt_q == SCNT_ONE);
      // Refill in the same edge the last bit leaves, so a steady stream has no bubble
      transfer     = hold_valid_q && (sreg_empty || last_bit);
      sreg_d       = sreg_q;
      sreg_cnt_d   = sreg_cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (clear) begin
         sreg_d       = '0;
         sreg_cnt_d   = '0;
         hold_d       = '0;
         hold_valid_d = 1'b0;
      end else begin
         if (transfer) begin
            sreg_d       = hold_q;
            sreg_cnt_d   = SCNT_FULL;
            hold_valid_d = 1'b0;
         end else if (shift) begin
            sreg_d     = sreg_q >> 1;
            sreg_cnt_d = sreg_cnt_q - SCNT_ONE;
         end
         // load_en is only offered while hold is empty, so it never collides with transfer
         if (load_en) begin
            hold_d       = load_data;
            hold_valid_d = 1'b1;
         end
      end
   end

   // Register update with asynchronous clear
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         sreg_q       <= '0;
         sreg_cnt_q   <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         sreg_q       <= sreg_d;
         sreg_cnt_q   <= sreg_cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   // Status outputs
   always_comb begin
      hold_valid    = hold_valid_q;
      sreg_nonempty = (sreg_cnt_q != '0);
      sreg_bit0     = sreg_q[0];
   end

endmodule

// File: rtl/frac_lut4_ccff_loader.sv
// Loads a bitstream into an external configuration flip-flop chain, one bit per shift cycle.
module frac_lut4_ccff_loader
   import frac_lut4_ccff_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 17,
   parameter int unsigned DATA_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              word_valid,
   input  logic [DATA_W-1:0] word_data,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              tail_parity
);

   localparam int unsigned NWORDS = ccff_nwords(CHAIN_LEN, DATA_W);
   localparam int unsigned BCNT_W = ccff_cnt_w(CHAIN_LEN);
   localparam int unsigned WCNT_W = ccff_cnt_w(NWORDS);

   localparam logic [BCNT_W-1:0] BITS_TOTAL  = BCNT_W'(CHAIN_LEN);
   localparam logic [BCNT_W-1:0] BITS_LAST   = BCNT_W'(CHAIN_LEN - 1);
   localparam logic [BCNT_W-1:0] BITS_ONE    = BCNT_W'(1);
   localparam logic [WCNT_W-1:0] WORDS_TOTAL = WCNT_W'(NWORDS);
   localparam logic [WCNT_W-1:0] WORDS_ONE   = WCNT_W'(1);

   logic [1:0]        state_q, state_d;
   logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
   logic              parity_q, parity_d;

   logic in_load;
   logic clear;
   logic word_accept;
   logic hold_valid;
   logic sreg_nonempty;
   logic sreg_bit0;
   logic shift_en;

   // Handshake and chain-drive decode
   always_comb begin
      in_load     = (state_q == StLoad);
      clear       = (state_q == StIdle) && start;
      word_ready  = in_load && !hold_valid && (word_cnt_q < WORDS_TOTAL);
      word_accept = word_valid && word_ready;
      // Underrun simply holds the chain; leftover bits of the last word are never shifted
      shift_en    = in_load && sreg_nonempty && (bit_cnt_q < BITS_TOTAL);
   end

   frac_lut4_ccff_serializer #(
      .DATA_W (DATA_W)
   ) u_serializer (
      .prog_clk      (prog_clk),
      .prog_reset_n  (prog_reset_n),
      .clear         (clear),
      .load_en       (word_accept),
      .load_data     (word_data),
      .shift         (shift_en),
      .hold_valid    (hold_valid),
      .sreg_nonempty (sreg_nonempty),
      .sreg_bit0     (sreg_bit0)
   );

   // FSM, bit/word counters and tail parity next-state
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      parity_d   = parity_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StLoad;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               parity_d   = 1'b0;
            end
         end
         StLoad: begin
            if (word_accept) begin
               word_cnt_d = word_cnt_q + WORDS_ONE;
            end
            if (shift_en) begin
               bit_cnt_d = bit_cnt_q + BITS_ONE;
               parity_d  = parity_q ^ ccff_tail;
               if (bit_cnt_q == BITS_LAST) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         parity_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         parity_q   <= parity_d;
      end
   end

   // Outputs decoded from registered state so reset clears them immediately
   always_comb begin
      ccff_shift_en = shift_en;
      ccff_head     = shift_en ? sreg_bit0 : 1'b0;
      busy          = (state_q == StLoad) || (state_q == StDone);
      done          = (state_q == StDone);
      tail_parity   = parity_q;
   end

endmodule

// File: tb/tb_frac_lut4_ccff_loader.sv
// Directed bench for frac_lut4_ccff_loader with a 17-bit chain model on the shift enable.
module tb_frac_lut4_ccff_loader;

   localparam int unsigned CHAIN_LEN = 17;
   localparam int unsigned DATA_W    = 8;

   logic              prog_clk     = 1'b0;
   logic              prog_reset_n = 1'b0;
   logic              start        = 1'b0;
   logic              word_valid   = 1'b0;
   logic [DATA_W-1:0] word_data    = '0;
   logic              word_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;
   logic              busy;
   logic              done;
   logic              tail_parity;

   logic [CHAIN_LEN-1:0] chain = '0;

   int vectors     = 0;
   int miscompares = 0;

   // Per-load observations
   int                   n_shift;
   int                   n_accept;
   int                   n_done;
   int                   n_stall;
   int                   first_shift;
   int                   last_shift;
   logic [CHAIN_LEN-1:0] heads;

   always #5 prog_clk = ~prog_clk;

   frac_lut4_ccff_loader #(
      .CHAIN_LEN (CHAIN_LEN),
      .DATA_W    (DATA_W)
   ) dut (
      .prog_clk      (prog_clk),
      .prog_reset_n  (prog_reset_n),
      .start         (start),
      .word_valid    (word_valid),
      .word_data     (word_data),
      .word_ready    (word_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done),
      .tail_parity   (tail_parity)
   );

   // Chain model: mem_out[0] takes the head, mem_out[16] is the tail
   always_ff @(posedge prog_clk) begin
      if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   end
   assign ccff_tail = chain[CHAIN_LEN-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check(tag, 32'({word_ready, ccff_head, ccff_shift_en, busy, done, tail_parity}), 32'd0);
   endtask

   // Drives one load cycle by cycle; gap withholds word_valid after the first word,
   // mid_start re-pulses start during LOAD, abort_at asserts reset after that many shifts.
   task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int gap, input bit mid_start, input int abort_at);
      logic [7:0] w [3];
      int idx;
      int gap_left;
      int cyc;
      bit fin;
      w[0] = w0; w[1] = w1; w[2] = w2;
      idx = 0; gap_left = gap; cyc = 0; fin = 1'b0;
      n_shift = 0; n_accept = 0; n_done = 0; n_stall = 0;
      first_shift = -1; last_shift = -1; heads = '0;
      while (!fin && cyc < 200) begin
         @(negedge prog_clk);
         start      = (cyc == 0) || (mid_start && cyc == 6);
         word_valid = !(idx == 1 && gap_left > 0);
         // A fourth word (0xEE) stays on offer once three are taken
         word_data  = (idx < 3) ? w[idx] : 8'hEE;
         #1;
         if (idx == 1 && gap_left > 0) gap_left--;
         if (word_valid && word_ready) begin
            idx++;
            n_accept++;
         end
         if (ccff_shift_en) begin
            n_shift++;
            heads = {heads[CHAIN_LEN-2:0], ccff_head};
            if (first_shift < 0) first_shift = cyc;
            last_shift = cyc;
         end else if (busy && !done && n_shift > 0) begin
            n_stall++;
         end
         if (done) n_done++;
         if (n_done > 0 && !busy) fin = 1'b1;
         if (abort_at > 0 && n_shift == abort_at) begin
            @(posedge prog_clk);
            #2;
            prog_reset_n = 1'b0;
            #1;
            check_idle_outputs("reset_mid_load_outputs");
            @(negedge prog_clk);
            prog_reset_n = 1'b1;
            fin = 1'b1;
         end
         cyc++;
      end
      start      = 1'b0;
      word_valid = 1'b0;
      check("load_finished_in_bound", 32'(fin), 32'd1);
   endtask

   task automatic check_load(input string tag, input logic [CHAIN_LEN-1:0] exp_chain,
                             input logic exp_par, input int exp_stall);
      check({tag, "_shifts"},  32'(n_shift),  32'd17);
      check({tag, "_accepts"}, 32'(n_accept), 32'd3);
      check({tag, "_done"},    32'(n_done),   32'd1);
      check({tag, "_stall"},   32'(n_stall),  32'(exp_stall));
      check({tag, "_heads"},   32'(heads),    32'(exp_chain));
      check({tag, "_chain"},   32'(chain),    32'(exp_chain));
      check({tag, "_parity"},  32'(tail_parity), 32'(exp_par));
   endtask

   initial begin
      // Reset state
      #1;
      check_idle_outputs("reset_outputs");
      repeat (2) @(negedge prog_clk);
      prog_reset_n = 1'b1;

      // A5,3C,01 streamed without gaps; stream 1010_0101_0011_1100_1 -> 17'h14A79
      run_load(8'hA5, 8'h3C, 8'h01, 0, 1'b0, 0);
      check_load("basic", 17'h14A79, 1'b0, 0);
      check("basic_contiguous", 32'(last_shift - first_shift + 1), 32'd17);
      check("basic_mem_out16", 32'(chain[16]), 32'd1);
      check("basic_mem_out0",  32'(chain[0]),  32'd1);

      // 12-cycle withhold: sreg drains after 8 shifts, refill arrives 5 cycles later.
      // Tail sees 17'h14A79 (nine ones) -> parity 1.
      run_load(8'hA5, 8'h3C, 8'h01, 12, 1'b0, 0);
      check_load("stall12", 17'h14A79, 1'b1, 5);

      // 5-cycle withhold is hidden behind the 8 buffered bits; start re-pulsed mid-load
      run_load(8'hA5, 8'h3C, 8'h01, 5, 1'b1, 0);
      check_load("stall5_midstart", 17'h14A79, 1'b1, 0);

      // Last word 0xFF: only its bit 0 is shifted
      run_load(8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 0);
      check_load("ones", 17'h1FFFF, 1'b1, 0);

      // Zeros over all-ones chain: seventeen ones at the tail -> parity 1
      run_load(8'h00, 8'h00, 8'h00, 0, 1'b0, 0);
      check_load("zeros_a", 17'h00000, 1'b1, 0);
      repeat (3) @(negedge prog_clk);
      check("zeros_a_parity_hold", 32'(tail_parity), 32'd1);

      // Zeros again: tail all zero -> parity 0
      run_load(8'h00, 8'h00, 8'h00, 0, 1'b0, 0);
      check_load("zeros_b", 17'h00000, 1'b0, 0);

      // Abort after 9 shifts (chain holds 0_0000_0001_0100_1010), then full reload.
      // Tail sees four ones -> parity 0.
      run_load(8'hA5, 8'h3C, 8'h01, 0, 1'b0, 9);
      check("abort_chain", 32'(chain), 32'h0014A);
      check_idle_outputs("after_abort_outputs");
      run_load(8'hA5, 8'h3C, 8'h01, 0, 1'b0, 0);
      check_load("reload", 17'h14A79, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
